search_and_add_sched: RTL and testbench

SEARCH_AND_ADD_SCHED -- requirements
Module: search_and_add_sched

---
 rtl/search_and_add_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_search_and_add_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/search_and_add_sched.sv
// search_and_add_sched: splits a job of N 512-bit words starting at a byte
// address into chunks of at most CHUNK_WORDS words. Each chunk is handed to
// search_and_add_ctrl with a one-cycle kick, and the next chunk is issued
// only after that controller has raised and then dropped busy.
//
// Handshake to search_and_add_ctrl: kick is a single-cycle pulse. The
// controller acknowledges it by raising busy and ends the chunk by dropping
// busy. num_of_words and memory_offset are held from kick until busy falls.
// kick is never repeated for the same chunk.
//
// Optional feature: define SEARCH_AND_ADD_SCHED_PERF_EN to build the
// job-cycle counter on perf_cycles. Without it, perf_cycles is constant 0.
//
// dbg_state exposes the FSM encoding (0 IDLE, 1 ISSUE, 2 WAIT_HI,
// 3 WAIT_LO, 4 FIN) so that checkers can follow the sequencing.
module search_and_add_sched #(
    parameter int CHUNK_WORDS = 1024,
    parameter int WORD_BYTES  = 64
) (
    input  logic        clk,
    input  logic        reset,
    // job side
    input  logic        job_kick,
    input  logic [31:0] job_num_of_words,
    input  logic [63:0] job_memory_offset,
    input  logic        job_abort,
    output logic        job_busy,
    output logic        job_done,
    output logic        job_aborted,
    output logic [31:0] chunks_issued,
    // search_and_add_ctrl side
    output logic        kick,
    input  logic        busy,
    output logic [31:0] num_of_words,
    output logic [63:0] memory_offset,
    // statistics and debug
    output logic [31:0] perf_cycles,
    output logic [2:0]  dbg_state
);

    localparam logic [31:0] CHUNK_W = 32'(CHUNK_WORDS);
    localparam logic [63:0] WORD_B  = 64'(WORD_BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic        job_busy_q,      job_busy_d;
    logic        job_done_q,      job_done_d;
    logic        job_aborted_q,   job_aborted_d;
    logic        kick_q,          kick_d;
    logic [31:0] chunks_issued_q, chunks_issued_d;
    logic [31:0] num_of_words_q,  num_of_words_d;
    logic [63:0] memory_offset_q, memory_offset_d;
    logic [31:0] remaining_q,     remaining_d;
    logic [63:0] next_addr_q,     next_addr_d;

    // Derived chunk arithmetic. num_of_words_q always holds the size of the
    // chunk in flight, so it doubles as the amount to retire from remaining.
    logic        job_accept;
    logic [31:0] chunk_words;
    logic [31:0] remaining_after;
    logic [63:0] chunk_bytes;

    // A job_kick is accepted only in IDLE; job_busy is low exactly there.
    assign job_accept      = (state_q == S_IDLE) && job_kick;
    assign chunk_words     = (remaining_q < CHUNK_W) ? remaining_q : CHUNK_W;
    assign remaining_after = remaining_q - num_of_words_q;
    assign chunk_bytes     = {32'd0, num_of_words_q} * WORD_B;

    // State register: asynchronous reset drops any job in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort is only sampled in ISSUE, so an in-flight
    // chunk always runs to completion before the job ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (job_kick) begin
                    state_d = (job_num_of_words == 32'd0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = job_abort ? S_FIN : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    state_d = (remaining_after == 32'd0) ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values. All outputs are registered, which
    // gives kick two cycles after an accepted job_kick or a busy fall.
    always_comb begin
        job_busy_d      = job_busy_q;
        job_done_d      = 1'b0;
        job_aborted_d   = job_aborted_q;
        kick_d          = 1'b0;
        chunks_issued_d = chunks_issued_q;
        num_of_words_d  = num_of_words_q;
        memory_offset_d = memory_offset_q;
        remaining_d     = remaining_q;
        next_addr_d     = next_addr_q;

        case (state_q)
            S_IDLE: begin
                if (job_accept) begin
                    remaining_d     = job_num_of_words;
                    next_addr_d     = job_memory_offset;
                    chunks_issued_d = 32'd0;
                    job_aborted_d   = 1'b0;
                    job_busy_d      = 1'b1;
                end
            end
            S_ISSUE: begin
                if (job_abort) begin
                    job_aborted_d = 1'b1;
                end else begin
                    num_of_words_d  = chunk_words;
                    memory_offset_d = next_addr_q;
                    kick_d          = 1'b1;
                    chunks_issued_d = chunks_issued_q + 32'd1;
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    remaining_d = remaining_after;
                    // 64-bit add: addresses wrap modulo 2^64 by design.
                    next_addr_d = next_addr_q + chunk_bytes;
                end
            end
            S_FIN: begin
                job_done_d = 1'b1;
                job_busy_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job_busy_q      <= 1'b0;
            job_done_q      <= 1'b0;
            job_aborted_q   <= 1'b0;
            kick_q          <= 1'b0;
            chunks_issued_q <= 32'd0;
            num_of_words_q  <= 32'd0;
            memory_offset_q <= 64'd0;
            remaining_q     <= 32'd0;
            next_addr_q     <= 64'd0;
        end else begin
            job_busy_q      <= job_busy_d;
            job_done_q      <= job_done_d;
            job_aborted_q   <= job_aborted_d;
            kick_q          <= kick_d;
            chunks_issued_q <= chunks_issued_d;
            num_of_words_q  <= num_of_words_d;
            memory_offset_q <= memory_offset_d;
            remaining_q     <= remaining_d;
            next_addr_q     <= next_addr_d;
        end
    end

`ifdef SEARCH_AND_ADD_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;

    // Job cycle counter: cleared on an accepted job, counts every cycle with
    // job_busy high, saturates, and holds its value once the job is done.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        if (job_accept) begin
            perf_cycles_d = 32'd0;
        end else if (job_busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q <= 32'd0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
`else
    assign perf_cycles = 32'd0;
`endif

    assign job_busy      = job_busy_q;
    assign job_done      = job_done_q;
    assign job_aborted   = job_aborted_q;
    assign chunks_issued = chunks_issued_q;
    assign kick          = kick_q;
    assign num_of_words  = num_of_words_q;
    assign memory_offset = memory_offset_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_search_and_add_sched.sv
// Testbench for search_and_add_sched: table of jobs plus hand-written reset
// and double-kick sequences. A behavioural search_and_add_ctrl model answers
// every kick and checks each chunk against a queue of expected chunks.
module tb_search_and_add_sched;

  localparam int CHUNK = 1024;
  localparam int WBYTES = 64;

  logic        clk;
  logic        reset;
  logic        job_kick;
  logic [31:0] job_num_of_words;
  logic [63:0] job_memory_offset;
  logic        job_abort;
  logic        job_busy;
  logic        job_done;
  logic        job_aborted;
  logic [31:0] chunks_issued;
  logic        kick;
  logic        busy;
  logic [31:0] num_of_words;
  logic [63:0] memory_offset;
  logic [31:0] perf_cycles;
  logic [2:0]  dbg_state;

  typedef struct {
    logic [31:0] nw;
    logic [63:0] off;
    bit          abort;
    bit          dbl;
    int          exp_chunks;
    bit          exp_aborted;
  } job_t;

  // expected chunk = {num_of_words, memory_offset}
  logic [95:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_kick_cyc = -1;
  int kick_cnt = 0;
  int done_cnt = 0;
  int busy_cycles = 0;
  int busy_len = 10;

  search_and_add_sched #(
    .CHUNK_WORDS(CHUNK),
    .WORD_BYTES (WBYTES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .job_kick         (job_kick),
    .job_num_of_words (job_num_of_words),
    .job_memory_offset(job_memory_offset),
    .job_abort        (job_abort),
    .job_busy         (job_busy),
    .job_done         (job_done),
    .job_aborted      (job_aborted),
    .chunks_issued    (chunks_issued),
    .kick             (kick),
    .busy             (busy),
    .num_of_words     (num_of_words),
    .memory_offset    (memory_offset),
    .perf_cycles      (perf_cycles),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ctrl model + scoreboard ----------------
  initial begin
    logic        busy_pend;
    int          busy_cnt;
    logic        prev_kick;
    logic [95:0] cur;
    logic [95:0] e;
    busy = 1'b0;
    busy_pend = 1'b0;
    busy_cnt = 0;
    prev_kick = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
        busy_pend = 1'b0;
        busy_cnt = 0;
        prev_kick = 1'b0;
      end else begin
        if (job_busy) busy_cycles++;
        if (job_done) done_cnt++;
        if (busy) begin
          chk("chunk_words_stable", num_of_words, cur[95:64]);
          chk("chunk_offset_stable", memory_offset, cur[63:0]);
          busy_cnt--;
          if (busy_cnt == 0) begin
            busy = 1'b0;
            exp_kick_cyc = cyc + 2;
          end
        end
        if (kick) begin
          kick_cnt++;
          chk("kick_one_cycle", prev_kick, 1'b0);
          chk("kick_latency", cyc, exp_kick_cyc);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL kick_unexpected actual_words=%0d actual_offset=0x%0h expected=no_kick", num_of_words, memory_offset);
          end else begin
            e = exp_q.pop_front();
            cur = e;
            chk("chunk_words", num_of_words, e[95:64]);
            chk("chunk_offset", memory_offset, e[63:0]);
          end
          busy_pend = 1'b1;
        end else if (busy_pend) begin
          busy = 1'b1;
          busy_cnt = busy_len;
          busy_pend = 1'b0;
        end
        prev_kick = kick;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_job(input job_t j, input int id);
    logic [31:0] rem;
    logic [31:0] c;
    logic [63:0] addr;
    logic [63:0] exp_perf;
    int          drive_cyc;
    int          done_cyc;
    bit          got;
    rem = j.nw;
    addr = j.off;
    while (rem != 0) begin
      c = (rem > 32'(CHUNK)) ? 32'(CHUNK) : rem;
      exp_q.push_back({c, addr});
      rem = rem - c;
      addr = addr + 64'(c) * 64'(WBYTES);
      if (j.abort) break;
    end
    job_num_of_words = j.nw;
    job_memory_offset = j.off;
    job_kick = 1'b1;
    drive_cyc = cyc;
    exp_kick_cyc = cyc + 2;
    kick_cnt = 0;
    busy_cycles = 0;
    done_cnt = 0;
    @(negedge clk);
    job_kick = 1'b0;
    job_num_of_words = 32'h5A5A;
    job_memory_offset = 64'hDEAD_0000;
    chk($sformatf("j%0d_busy_after_kick", id), job_busy, 1'b1);
    chk($sformatf("j%0d_aborted_cleared", id), job_aborted, 1'b0);
    if (j.dbl) begin
      repeat (3) @(negedge clk);
      job_num_of_words = 32'd7;
      job_memory_offset = 64'h5555;
      job_kick = 1'b1;
      @(negedge clk);
      job_kick = 1'b0;
    end
    got = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (j.abort && busy) job_abort = 1'b1;
      if (job_done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("j%0d_done_seen", id), got, 1'b1);
    if (j.nw == 0) chk($sformatf("j%0d_zero_done_latency", id), done_cyc - drive_cyc, 2);
    chk($sformatf("j%0d_busy_low_at_done", id), job_busy, 1'b0);
    chk($sformatf("j%0d_aborted", id), job_aborted, j.exp_aborted);
    chk($sformatf("j%0d_chunks_issued", id), chunks_issued, j.exp_chunks);
    chk($sformatf("j%0d_kick_count", id), kick_cnt, j.exp_chunks);
    chk($sformatf("j%0d_queue_empty", id), exp_q.size(), 0);
`ifdef SEARCH_AND_ADD_SCHED_PERF_EN
    exp_perf = 64'(busy_cycles);
`else
    exp_perf = 64'd0;
`endif
    chk($sformatf("j%0d_perf_cycles", id), perf_cycles, exp_perf);
    job_abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("j%0d_done_single_pulse", id), done_cnt, 1);
    chk($sformatf("j%0d_done_low", id), job_done, 1'b0);
    chk($sformatf("j%0d_aborted_held", id), job_aborted, j.exp_aborted);
    chk($sformatf("j%0d_perf_held", id), perf_cycles, exp_perf);
    chk($sformatf("j%0d_state_idle", id), dbg_state, 3'd0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_job_busy"}, job_busy, 1'b0);
    chk({tag, "_job_done"}, job_done, 1'b0);
    chk({tag, "_job_aborted"}, job_aborted, 1'b0);
    chk({tag, "_kick"}, kick, 1'b0);
    chk({tag, "_chunks_issued"}, chunks_issued, 32'd0);
    chk({tag, "_num_of_words"}, num_of_words, 32'd0);
    chk({tag, "_memory_offset"}, memory_offset, 64'd0);
    chk({tag, "_perf_cycles"}, perf_cycles, 32'd0);
    chk({tag, "_state"}, dbg_state, 3'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    job_t vec[8];
    job_t post;
    logic [31:0] rnd;
    reset = 1'b1;
    job_kick = 1'b0;
    job_num_of_words = '0;
    job_memory_offset = '0;
    job_abort = 1'b0;

    vec[0] = '{nw: 32'd128,  off: 64'h8000_0000,          abort: 0, dbl: 0, exp_chunks: 1, exp_aborted: 0};
    vec[1] = '{nw: 32'd2500, off: 64'h0,                  abort: 0, dbl: 0, exp_chunks: 3, exp_aborted: 0};
    vec[2] = '{nw: 32'd0,    off: 64'h1234,               abort: 0, dbl: 0, exp_chunks: 0, exp_aborted: 0};
    vec[3] = '{nw: 32'd1024, off: 64'h1000,               abort: 0, dbl: 0, exp_chunks: 1, exp_aborted: 0};
    vec[4] = '{nw: 32'd1025, off: 64'hFFFF_FFFF_FFFF_0000, abort: 0, dbl: 0, exp_chunks: 2, exp_aborted: 0};
    vec[5] = '{nw: 32'd2048, off: 64'h40,                 abort: 0, dbl: 0, exp_chunks: 2, exp_aborted: 0};
    vec[6] = '{nw: 32'd2500, off: 64'h100,                abort: 1, dbl: 0, exp_chunks: 1, exp_aborted: 1};
    rnd = 32'($urandom_range(1, 3000));
    vec[7] = '{nw: rnd, off: {32'($urandom), 32'($urandom)}, abort: 0, dbl: 0,
               exp_chunks: int'((rnd + 32'(CHUNK) - 1) / 32'(CHUNK)), exp_aborted: 0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      busy_len = (i == 7) ? $urandom_range(1, 12) : 10;
      run_job(vec[i], i);
    end

    // reset while the first chunk of a 3-chunk job is in WAIT_LO
    busy_len = 10;
    exp_q.push_back({32'd1024, 64'd0});
    job_num_of_words = 32'd2500;
    job_memory_offset = 64'd0;
    job_kick = 1'b1;
    exp_kick_cyc = cyc + 2;
    kick_cnt = 0;
    @(negedge clk);
    job_kick = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("midjob_state_wait_lo", dbg_state, 3'd3);
    #2 reset = 1'b1;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    kick_cnt = 0;
    repeat (12) @(negedge clk);
    chk("postreset_no_done", done_cnt, 0);
    chk("postreset_no_kick", kick_cnt, 0);
    chk("postreset_idle", job_busy, 1'b0);

    post = '{nw: 32'd128, off: 64'h8000_0000, abort: 0, dbl: 1, exp_chunks: 1, exp_aborted: 0};
    run_job(post, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
